// File: rtl/geo_polyline_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : geo_polyline_sequencer
// Description : Turns a stream of vertices into line requests for the line
//               generator. Vertices are queued in a small FIFO. Each
//               consecutive pair is presented as one line, and ln_run is held
//               high until the generator reports completion. A path can
//               optionally be closed back to its first vertex. All
//               generator-facing progress is frozen while draw_busy is high.
// Ports       : clk, reset         - clock, synchronous active-high reset
//               i_draw_busy        - shared pixel-writer stall
//               i_vtx_*/o_vtx_ready - vertex stream (valid/ready handshake)
//               i_close_path       - close request, sampled when the path's
//                                    first vertex is loaded
//               o_ln_run, o_ln_*   - run strobe and endpoints to the generator
//               i_ln_complete      - generator line_complete
//               o_seq_busy, o_path_done, o_line_count - status
// Revision    : 1.0 - initial release
// ============================================================================
module geo_polyline_sequencer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_draw_busy,
  input  logic               i_vtx_valid,
  output logic               o_vtx_ready,
  input  logic signed [11:0] i_vtx_x,
  input  logic signed [11:0] i_vtx_y,
  input  logic               i_vtx_last,
  input  logic               i_close_path,
  output logic               o_ln_run,
  output logic signed [11:0] o_ln_ax,
  output logic signed [11:0] o_ln_ay,
  output logic signed [11:0] o_ln_bx,
  output logic signed [11:0] o_ln_by,
  input  logic               i_ln_complete,
  output logic               o_seq_busy,
  output logic               o_path_done,
  output logic [15:0]        o_line_count
);

  localparam int            c_ADDR_W = $clog2(FIFO_DEPTH);
  localparam logic [c_ADDR_W:0] c_FULL = (c_ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_DROP   = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // Vertex FIFO
  // --------------------------------------------------------------------------
  logic signed [11:0]  r_mem_x    [FIFO_DEPTH];
  logic signed [11:0]  r_mem_y    [FIFO_DEPTH];
  logic                r_mem_last [FIFO_DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_ADDR_W:0]   r_count;

  logic                w_push;
  logic                w_pop;
  logic                w_empty;
  logic signed [11:0]  w_head_x;
  logic signed [11:0]  w_head_y;
  logic                w_head_last;

  state_t              r_state;

  // Ready looks only at the pre-pop count, so a full FIFO refuses a push even
  // on the cycle it pops; this keeps vtx_ready independent of the FSM.
  assign o_vtx_ready = (r_count != c_FULL);
  assign w_push      = i_vtx_valid && o_vtx_ready;
  assign w_empty     = (r_count == '0);
  // LOAD_A is only entered with a non-empty FIFO and nothing else pops.
  assign w_pop       = (r_state == ST_LOAD_A) || ((r_state == ST_LOAD_B) && !w_empty);
  assign w_head_x    = r_mem_x[r_rd_ptr];
  assign w_head_y    = r_mem_y[r_rd_ptr];
  assign w_head_last = r_mem_last[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_x[r_wr_ptr]    <= i_vtx_x;
      r_mem_y[r_wr_ptr]    <= i_vtx_y;
      r_mem_last[r_wr_ptr] <= i_vtx_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Depth is a power of two, so the pointers wrap naturally.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  logic signed [11:0] r_ax, r_ay, r_bx, r_by;
  logic signed [11:0] r_fx, r_fy;      // first vertex of the path
  logic               r_b_last;
  logic               r_close;
  logic               r_closing;       // closing line already issued
  logic               r_run;
  logic               r_busy;
  logic               r_path_done;
  logic [15:0]        r_line_count;
  logic               w_b_is_first;

  assign w_b_is_first = (r_bx == r_fx) && (r_by == r_fy);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_ax         <= '0;
      r_ay         <= '0;
      r_bx         <= '0;
      r_by         <= '0;
      r_fx         <= '0;
      r_fy         <= '0;
      r_b_last     <= 1'b0;
      r_close      <= 1'b0;
      r_closing    <= 1'b0;
      r_run        <= 1'b0;
      r_busy       <= 1'b0;
      r_path_done  <= 1'b0;
      r_line_count <= '0;
    end else begin
      r_path_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_state <= ST_LOAD_A;
            r_busy  <= 1'b1;
          end
        end

        ST_LOAD_A: begin
          r_ax         <= w_head_x;
          r_ay         <= w_head_y;
          r_fx         <= w_head_x;
          r_fy         <= w_head_y;
          r_close      <= i_close_path;
          r_closing    <= 1'b0;
          r_line_count <= '0;
          if (w_head_last) begin
            // Single-vertex path: degenerate line plots one point.
            r_bx     <= w_head_x;
            r_by     <= w_head_y;
            r_b_last <= 1'b1;
            r_run    <= 1'b1;
            r_state  <= ST_ISSUE;
          end else begin
            r_state  <= ST_LOAD_B;
          end
        end

        ST_LOAD_B: begin
          if (!w_empty) begin
            r_bx     <= w_head_x;
            r_by     <= w_head_y;
            r_b_last <= w_head_last;
            r_run    <= 1'b1;
            r_state  <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          // The generator latches its start on the first non-stalled edge.
          if (!i_draw_busy) r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (i_ln_complete && !i_draw_busy) begin
            if (r_line_count != 16'hFFFF) r_line_count <= r_line_count + 16'd1;
            r_run   <= 1'b0;
            r_state <= ST_DROP;
          end
        end

        ST_DROP: begin
          // Run stays low until the generator has seen it low on a live edge.
          if (!i_draw_busy) begin
            if (!r_b_last) begin
              r_ax    <= r_bx;
              r_ay    <= r_by;
              r_state <= ST_LOAD_B;
            end else if (r_close && !w_b_is_first && !r_closing) begin
              r_ax      <= r_bx;
              r_ay      <= r_by;
              r_bx      <= r_fx;
              r_by      <= r_fy;
              r_closing <= 1'b1;
              r_run     <= 1'b1;
              r_state   <= ST_ISSUE;
            end else begin
              r_path_done <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_run   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ln_run     = r_run;
  assign o_ln_ax      = r_ax;
  assign o_ln_ay      = r_ay;
  assign o_ln_bx      = r_bx;
  assign o_ln_by      = r_by;
  assign o_seq_busy   = r_busy;
  assign o_path_done  = r_path_done;
  assign o_line_count = r_line_count;

endmodule
`default_nettype wire

// File: tb/tb_geo_polyline_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_geo_polyline_sequencer
// Description : Self-checking bench for geo_polyline_sequencer. A path-level
//               model turns every pushed vertex into the lines a polyline
//               must produce; a per-cycle monitor emulates the line generator
//               and compares issued lines and path results with the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_geo_polyline_sequencer;

  typedef struct packed {
    logic signed [11:0] ax;
    logic signed [11:0] ay;
    logic signed [11:0] bx;
    logic signed [11:0] by;
  } line_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               i_draw_busy = 1'b0;
  logic               i_vtx_valid = 1'b0;
  logic               o_vtx_ready;
  logic signed [11:0] i_vtx_x = '0;
  logic signed [11:0] i_vtx_y = '0;
  logic               i_vtx_last = 1'b0;
  logic               i_close_path = 1'b0;
  logic               o_ln_run;
  logic signed [11:0] o_ln_ax, o_ln_ay, o_ln_bx, o_ln_by;
  logic               i_ln_complete = 1'b0;
  logic               o_seq_busy;
  logic               o_path_done;
  logic [15:0]        o_line_count;

  always #5 clk = ~clk;

  geo_polyline_sequencer #(.FIFO_DEPTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_draw_busy  (i_draw_busy),
    .i_vtx_valid  (i_vtx_valid),
    .o_vtx_ready  (o_vtx_ready),
    .i_vtx_x      (i_vtx_x),
    .i_vtx_y      (i_vtx_y),
    .i_vtx_last   (i_vtx_last),
    .i_close_path (i_close_path),
    .o_ln_run     (o_ln_run),
    .o_ln_ax      (o_ln_ax),
    .o_ln_ay      (o_ln_ay),
    .o_ln_bx      (o_ln_bx),
    .o_ln_by      (o_ln_by),
    .i_ln_complete(i_ln_complete),
    .o_seq_busy   (o_seq_busy),
    .o_path_done  (o_path_done),
    .o_line_count (o_line_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_line(input string name, input line_t act, input line_t exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got (%0d,%0d)->(%0d,%0d) expected (%0d,%0d)->(%0d,%0d) (t=%0t)",
               name, act.ax, act.ay, act.bx, act.by, exp.ax, exp.ay, exp.bx, exp.by, $time);
    end
  endtask

  function automatic line_t mk(input int ax, input int ay, input int bx, input int by);
    line_t l;
    l.ax = 12'(ax);
    l.ay = 12'(ay);
    l.bx = 12'(bx);
    l.by = 12'(by);
    return l;
  endfunction

  // --------------------------------------------------------------------------
  // Path-level model: expected lines and expected line count per path
  // --------------------------------------------------------------------------
  line_t exp_lines[$];
  int    exp_cnt[$];
  int    path_n = 0, path_lines = 0;
  int    fx, fy, px, py;
  bit    path_close = 0;

  task automatic start_path(input bit close);
    path_close   = close;
    i_close_path = close;
  endtask

  task automatic model_vertex(input int x, input int y, input bit last);
    if (path_n == 0) begin
      fx = x;
      fy = y;
    end else begin
      exp_lines.push_back(mk(px, py, x, y));
      path_lines++;
    end
    px = x;
    py = y;
    path_n++;
    if (last) begin
      if (path_n == 1) begin
        exp_lines.push_back(mk(x, y, x, y));
        path_lines++;
      end else if (path_close && (x != fx || y != fy)) begin
        exp_lines.push_back(mk(x, y, fx, fy));
        path_lines++;
      end
      exp_cnt.push_back(path_lines);
      path_n     = 0;
      path_lines = 0;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_vtx(input int x, input int y, input bit last);
    int t;
    model_vertex(x, y, last);
    i_vtx_valid = 1'b1;
    i_vtx_x     = 12'(x);
    i_vtx_y     = 12'(y);
    i_vtx_last  = last;
    t = 0;
    while (!o_vtx_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!o_vtx_ready) chk("push_timeout", 0, 1);
    @(negedge clk);
    i_vtx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_cnt.size() != 0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk("path_done_timeout", exp_cnt.size(), 0);
  endtask

  task automatic wait_run();
    int t;
    t = 0;
    while (!o_ln_run && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("run_seen", o_ln_run, 1);
  endtask

  // --------------------------------------------------------------------------
  // Generator emulation and per-cycle compare (sampled 1 ns after the edge)
  // --------------------------------------------------------------------------
  bit    gen_hold = 0, rand_busy = 0;
  bit    wait_stall_req = 0, drop_stall_req = 0;
  bit    captured = 0;
  int    lat = 0, stall_w = 0, stall_d = 0, lines_seen = 0;
  line_t cur, capt, last_line;

  always begin
    @(posedge clk);
    #1;
    cur = {o_ln_ax, o_ln_ay, o_ln_bx, o_ln_by};
    if (reset) begin
      captured      = 0;
      i_ln_complete = 1'b0;
      i_draw_busy   = 1'b0;
      stall_w       = 0;
      stall_d       = 0;
    end else begin
      if (o_ln_run) chk("seq_busy_with_run", o_seq_busy, 1);
      if (stall_w > 0) chk("wait_stall_run", o_ln_run, 1);
      if (stall_d > 0) begin
        chk("drop_stall_run", o_ln_run, 0);
        chk("drop_stall_done", o_path_done, 0);
        chk_line("drop_stall_coords", cur, capt);
        stall_d--;
      end
      if (o_ln_run) begin
        if (!captured) begin
          captured  = 1;
          capt      = cur;
          last_line = cur;
          lines_seen++;
          if (exp_lines.size() == 0) chk("unexpected_line", 1, 0);
          else chk_line("line", cur, exp_lines.pop_front());
          lat = $urandom_range(0, 4);
        end else begin
          chk_line("line_stable", cur, capt);
        end
        if (stall_w > 0) begin
          stall_w--;
        end else if (!gen_hold && !i_ln_complete) begin
          if (lat == 0) begin
            i_ln_complete = 1'b1;
            if (wait_stall_req) begin
              wait_stall_req = 0;
              stall_w        = 20;
            end
          end else if (!i_draw_busy) begin
            lat--;
          end
        end
      end else begin
        if (captured && drop_stall_req) begin
          drop_stall_req = 0;
          stall_d        = 20;
        end
        captured      = 0;
        i_ln_complete = 1'b0;
      end
      if (o_path_done) begin
        chk("done_seq_busy", o_seq_busy, 0);
        if (exp_cnt.size() == 0) chk("unexpected_path_done", 1, 0);
        else chk("line_count", o_line_count, exp_cnt.pop_front());
      end
      i_draw_busy = (stall_w > 0) || (stall_d > 0) ||
                    (rand_busy && $urandom_range(0, 3) == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int n0;
    repeat (3) @(negedge clk);
    chk("rst_vtx_ready", o_vtx_ready, 1);
    chk("rst_ln_run", o_ln_run, 0);
    chk_line("rst_coords", {o_ln_ax, o_ln_ay, o_ln_bx, o_ln_by}, mk(0, 0, 0, 0));
    chk("rst_seq_busy", o_seq_busy, 0);
    chk("rst_path_done", o_path_done, 0);
    chk("rst_line_count", o_line_count, 0);
    reset = 1'b0;
    @(negedge clk);

    // Open polyline
    n0 = lines_seen;
    start_path(0);
    push_vtx(0, 0, 0);
    push_vtx(10, 0, 0);
    push_vtx(10, 5, 1);
    wait_idle();
    chk("open_count", o_line_count, 2);
    chk("open_lines", lines_seen - n0, 2);
    chk_line("open_last", last_line, mk(10, 0, 10, 5));

    // Closed polygon
    n0 = lines_seen;
    start_path(1);
    push_vtx(0, 0, 0);
    push_vtx(10, 0, 0);
    push_vtx(10, 5, 1);
    wait_idle();
    chk("close_count", o_line_count, 3);
    chk("close_lines", lines_seen - n0, 3);
    chk_line("close_last", last_line, mk(10, 5, 0, 0));

    // Single vertex, with first-line latency
    start_path(0);
    push_vtx(7, -3, 1);
    @(negedge clk);
    chk("lat_run_n1", o_ln_run, 0);
    chk("lat_busy_n1", o_seq_busy, 1);
    @(negedge clk);
    chk("lat_run_n2", o_ln_run, 1);
    wait_idle();
    chk("single_count", o_line_count, 1);
    chk_line("single_line", last_line, mk(7, -3, 7, -3));

    // 20-cycle stalls in WAIT and in DROP
    wait_stall_req = 1;
    drop_stall_req = 1;
    start_path(0);
    push_vtx(0, 0, 0);
    push_vtx(10, 0, 0);
    push_vtx(10, 5, 1);
    wait_idle();
    chk("stalls_consumed", {wait_stall_req, drop_stall_req}, 0);
    chk("stall_count", o_line_count, 2);

    // Fill the FIFO behind a stalled generator
    gen_hold = 1;
    start_path(0);
    push_vtx(1, 1, 0);
    push_vtx(2, 2, 0);
    wait_run();
    for (int i = 0; i < 8; i++) begin
      chk("ready_before_full", o_vtx_ready, 1);
      push_vtx(3 + i, -i, 0);
    end
    chk("ready_full", o_vtx_ready, 0);
    fork
      push_vtx(20, 20, 1);
      begin
        repeat (5) @(negedge clk);
        gen_hold = 0;
      end
    join
    wait_idle();
    chk("full_count", o_line_count, 10);

    // Reset while a line is in flight
    gen_hold = 1;
    start_path(1);
    push_vtx(5, 5, 0);
    push_vtx(6, 5, 0);
    push_vtx(6, 6, 1);
    wait_run();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_lines.delete();
    exp_cnt.delete();
    path_n     = 0;
    path_lines = 0;
    @(negedge clk);
    chk("rstw_ln_run", o_ln_run, 0);
    chk("rstw_seq_busy", o_seq_busy, 0);
    chk("rstw_vtx_ready", o_vtx_ready, 1);
    reset    = 1'b0;
    gen_hold = 0;
    repeat (3) @(negedge clk);
    chk("rstw_fifo_empty", o_seq_busy, 0);
    start_path(0);
    push_vtx(0, 0, 0);
    push_vtx(10, 0, 0);
    push_vtx(10, 5, 1);
    wait_idle();
    chk("post_rst_count", o_line_count, 2);
    chk_line("post_rst_last", last_line, mk(10, 0, 10, 5));

    // Random paths with random stalls
    rand_busy = 1;
    for (int p = 0; p < 40; p++) begin
      int n, x, y, lx, ly;
      n = $urandom_range(1, 6);
      start_path(bit'($urandom_range(0, 1)));
      lx = 0;
      ly = 0;
      for (int v = 0; v < n; v++) begin
        if (v > 0 && $urandom_range(0, 4) == 0) begin
          x = lx;
          y = ly;
        end else begin
          x = int'($urandom_range(0, 200)) - 100;
          y = int'($urandom_range(0, 200)) - 100;
        end
        push_vtx(x, y, v == n - 1);
        lx = x;
        ly = y;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle();
    end
    rand_busy = 0;
    repeat (5) @(negedge clk);
    chk("leftover_lines", exp_lines.size(), 0);
    chk("final_idle", o_seq_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
